mdu_sequencer: RTL
==================

# mdu_sequencer

Multi-cycle multiply/divide unit and its sequencer for the P7 five-stage MIPS pipeline. It sits beside the ALU in the E stage and owns the HI/LO registers. It accepts a start or move operation from the instruction in E, runs a fixed-latency busy countdown, and commits results to HI/LO. It also generates the D-stage stall request for any MDU-related instruction while the unit is occupied, and suppresses issue when an exception or interrupt request is active.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset; asynchronous, active-low.
- `e_mduop`  in  3  op of the instruction in E: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `e_start`  in  1  the instruction in E is MULT/MULTU/DIV/DIVU.
- `e_rs`  in  32  forwarded rs operand in E.
- `e_rt`  in  32  forwarded rt operand in E.
- `req`  in  1  exception/interrupt taken this cycle; E instruction is being flushed.
- `d_mdu_related`  in  1  the instruction in D is an MDU op (mult/div/mthi/mtlo/mfhi/mflo).
- `busy`  out  1  a multi-cycle operation is in flight.
- `stall_mdu`  out  1  stall request to the hazard unit for D.
- `hi`  out  32  architectural HI (registered).
- `lo`  out  32  architectural LO (registered).

## Operation
- State: IDLE / RUN. `cnt` holds the remaining cycles. `busy = (state == RUN)`.
- Issue is accepted when `req == 0` and `e_start == 1` and the state is IDLE. The op and operands are latched, `cnt` loads MULT_CYCLES or DIV_CYCLES, and the state goes to RUN.
- RUN: `cnt` decrements each cycle. On the edge where `cnt` goes 1→0, HI/LO are written with the latched result and the state returns to IDLE.
- MULT: {HI,LO} = signed 64-bit product. MULTU: {HI,LO} = unsigned product.
- DIV: LO is the signed quotient, truncated toward zero. HI is the remainder, which takes the sign of the dividend. For 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV/DIVU with rt = 0): the busy sequence runs the full DIV_CYCLES, and HI/LO are left unchanged at completion.
- MTHI/MTLO: when `req == 0` and the state is IDLE, HI or LO is written with `e_rs` at the end of the E cycle. No busy period follows.
- `req == 1` suppresses any issue or MTHI/MTLO write in that cycle. An operation already in RUN is committed and runs to completion regardless of `req`.
- `e_start` or MTHI/MTLO arriving during RUN is ignored. This case cannot occur under a correct stall.
- `stall_mdu = d_mdu_related & (busy | e_start)`. This is combinational.
- Reset (asynchronous, at any time including mid-RUN): state IDLE, `cnt` = 0, `hi` = 0, `lo` = 0, `busy` = 0. Any in-flight result is discarded.

## Timing
- Start in cycle T: `busy` is high in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES). The new HI/LO values are visible from cycle T+N+1.
- MTHI/MTLO in cycle T: the new value is visible from T+1.
- `hi`/`lo` are register outputs. An mfhi/mflo in D is held by `stall_mdu` until `busy` falls, and then reads the committed value.
- `stall_mdu` is high in cycle T when D holds an MDU op and E holds a start. It stays high through T+N and falls in T+N+1.
- A back-to-back start is accepted in the cycle `busy` first reads 0.

## Test plan
- Signed multiply: MULT with rs = 0xFFFFFFFD (−3), rt = 5 → `busy` is high for exactly 5 cycles; then HI = 0xFFFFFFFF and LO = 0xFFFFFFF1.
- Signed divide and unsigned divide:
  - DIV with rs = 0xFFFFFFF9 (−7), rt = 2 → after 10 busy cycles, LO = 0xFFFFFFFD and HI = 0xFFFFFFFF.
  - DIVU with rs = 7, rt = 2 → LO = 3, HI = 1.
- Divide by zero and overflow:
  - Preload HI = 0x11, LO = 0x22 via MTHI/MTLO, then DIVU by 0 → 10 busy cycles, and HI = 0x11, LO = 0x22 remain.
  - 0x80000000 DIV 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Stall: MULT in E with mflo in D → `stall_mdu` is high for 6 consecutive cycles (start cycle + 5). In the 7th cycle, `stall_mdu` = 0 and `lo` already shows the product.
- Exception suppression:
  - MULT with `req = 1` in the same cycle → `busy` never rises and HI/LO are unchanged.
  - MTLO with `req = 1` → LO is unchanged.
  - Raising `req` during RUN still yields the result on schedule.
- Reset mid-operation: start a DIV, then assert `reset` low at cycle 4 of busy → `busy`, `hi` and `lo` go to 0 immediately (asynchronously). After release, a fresh MULT 2×3 produces LO = 6 and HI = 0 with a normal 5-cycle busy.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// E-stage request/response bundle for the MDU sequencer.
// The pipeline drives it as master; the MDU is the slave.
interface mdu_sequencer_if;
   logic [2:0]  e_mduop;
   logic        e_start;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        req;
   logic        d_mdu_related;
   logic        busy;
   logic        stall_mdu;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output e_mduop, e_start, e_rs, e_rt, req, d_mdu_related,
      input  busy, stall_mdu, hi, lo
   );

   modport slave (
      input  e_mduop, e_start, e_rs, e_rt, req, d_mdu_related,
      output busy, stall_mdu, hi, lo
   );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO for the E stage.
// Results are computed from latched operands and committed on the last busy edge.
module mdu_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic           clk,
   input  logic           reset,
   mdu_sequencer_if.slave bus
);

   localparam int CW = 16;
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    op_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;

   logic [63:0] prod_u;
   logic [63:0] prod_s;
   logic        div_s;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_res;
   logic [31:0] r_res;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
   always_comb begin
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      div_s  = (op_q == OP_DIV);
      a_neg  = div_s & a_q[31];
      b_neg  = div_s & b_q[31];
      a_mag  = a_neg ? (32'd0 - a_q) : a_q;
      b_mag  = b_neg ? (32'd0 - b_q) : b_q;
      b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      q_res  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      r_res  = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!bus.req && bus.e_start) begin
                  op_q  <= bus.e_mduop;
                  a_q   <= bus.e_rs;
                  b_q   <= bus.e_rt;
                  state <= RUN;
                  if (bus.e_mduop == OP_DIV || bus.e_mduop == OP_DIVU)
                     cnt <= DIV_N;
                  else
                     cnt <= MULT_N;
               end else if (!bus.req && bus.e_mduop == OP_MTHI) begin
                  hi_q <= bus.e_rs;
               end else if (!bus.req && bus.e_mduop == OP_MTLO) begin
                  lo_q <= bus.e_rs;
               end
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state <= IDLE;
                  unique case (op_q)
                     OP_MULT: begin
                        hi_q <= prod_s[63:32];
                        lo_q <= prod_s[31:0];
                     end
                     OP_MULTU: begin
                        hi_q <= prod_u[63:32];
                        lo_q <= prod_u[31:0];
                     end
                     OP_DIV, OP_DIVU: begin
                        if (b_q != 32'd0) begin
                           hi_q <= r_res;
                           lo_q <= q_res;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.stall_mdu = bus.d_mdu_related & ((state == RUN) | bus.e_start);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule
